mem_arbiter: RTL and testbench

- Shares the single RAM port between the instruction-fetch requester and the data-memory requester of the pipelined datapath.
- Sits between the datapath_cache_if requesters (imem*/dmem* side) and the RAM. Returns ihit/dhit with load data.
- Data requests have priority. A streak limit keeps instruction fetch from starving.
- A per-transaction timeout returns the arbiter to idle and flags an error if the RAM never completes.

---
 rtl/cpu_types_pkg.sv | 13 +
 rtl/mem_arbiter_if.sv | 19 +
 rtl/arb_timeout_counter.sv | 23 ++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: datapath word and memory arbiter state/defaults.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC
  } arb_state_t;

  localparam int unsigned MEM_ARB_TIMEOUT_DEFAULT = 64;
  localparam int unsigned MEM_ARB_DSTREAK_DEFAULT = 4;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's requester and RAM-side signals.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic  iREN, ihit, dREN, dWEN, dhit;
  logic  ramREN, ramWEN, ram_ready, err;
  word_t iaddr, iload, daddr, dstore, dload;
  word_t ramaddr, ramstore, ramload;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/arb_timeout_counter.sv
// Loadable up-counter with clear, increment enable and a terminal flag at LIMIT-1.
module arb_timeout_counter #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned LIMIT = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                 count <= '0;
    else if (clear)          count <= '0;
    else if (load)           count <= load_val;
    else if (inc && !terminal) count <= count + WIDTH'(1);
  end

  always_comb terminal = (count == WIDTH'(LIMIT - 1));
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data access,
// data first with a streak limit, plus a per-transaction timeout abort.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = MEM_ARB_DSTREAK_DEFAULT,
  parameter int unsigned TIMEOUT     = MEM_ARB_TIMEOUT_DEFAULT
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  iREN,
  input  word_t iaddr,
  output logic  ihit,
  output word_t iload,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output logic  dhit,
  output word_t dload,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  word_t ramload,
  input  logic  ram_ready,
  output logic  err
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);

  arb_state_t    state, state_next;
  logic [SW-1:0] streak, streak_next;
  logic [TW-1:0] tcount;
  word_t         lat_addr, lat_data;
  logic          lat_wr;
  logic          t_term, dreq, owner_req, grant_d, grant_i;

  arb_timeout_counter #(.WIDTH(TW), .LIMIT(TIMEOUT)) u_tcount (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (state == IDLE),
    .load     (1'b0),
    .load_val ('0),
    .inc      ((state != IDLE) && !ram_ready),
    .count    (tcount),
    .terminal (t_term)
  );

  always_comb begin
    dreq      = dREN | dWEN;
    owner_req = 1'b0;
    if (state == IACC) owner_req = iREN;
    if (state == DACC) owner_req = dreq;

    ihit  = (state == IACC) && ram_ready && iREN;
    dhit  = (state == DACC) && ram_ready && dreq;
    err   = (state != IDLE) && owner_req && !ram_ready && t_term;
    iload = ihit ? ramload : '0;
    dload = dhit ? ramload : '0;

    ramREN   = (state == IACC) || ((state == DACC) && !lat_wr);
    ramWEN   = (state == DACC) && lat_wr;
    ramaddr  = lat_addr;
    ramstore = lat_data;

    grant_d = (state == IDLE) && dreq && ((streak < SW'(MAX_DSTREAK)) || !iREN);
    grant_i = (state == IDLE) && !grant_d && iREN;

    state_next = state;
    case (state)
      IDLE:       if (grant_d) state_next = DACC;
                  else if (grant_i) state_next = IACC;
      IACC, DACC: if (!owner_req || ram_ready || t_term) state_next = IDLE;
      default:    state_next = IDLE;
    endcase

    // Streak only counts data wins that actually delayed a waiting fetch.
    streak_next = streak;
    if ((state == IDLE && !iREN) || ihit)
      streak_next = '0;
    else if (dhit && iREN && (streak < SW'(MAX_DSTREAK)))
      streak_next = streak + SW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      streak   <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_wr   <= 1'b0;
    end else begin
      state  <= state_next;
      streak <= streak_next;
      if (grant_d) begin
        lat_addr <= daddr;
        lat_data <= dstore;
        lat_wr   <= dWEN;
      end else if (grant_i) begin
        lat_addr <= iaddr;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int MAXD = 4;
  localparam int TO   = 8;

  logic CLK, RST;
  mem_arbiter_if abus ();

  mem_arbiter #(.MAX_DSTREAK(MAXD), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(abus.iREN), .iaddr(abus.iaddr), .ihit(abus.ihit), .iload(abus.iload),
    .dREN(abus.dREN), .dWEN(abus.dWEN), .daddr(abus.daddr), .dstore(abus.dstore),
    .dhit(abus.dhit), .dload(abus.dload),
    .ramREN(abus.ramREN), .ramWEN(abus.ramWEN), .ramaddr(abus.ramaddr),
    .ramstore(abus.ramstore), .ramload(abus.ramload), .ram_ready(abus.ram_ready),
    .err(abus.err)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the RAM (0 none, 1 fetch, 2 data),
  // what was captured at grant, how long the owner has waited.
  int          m_own, m_streak, m_wait;
  logic [31:0] m_addr, m_data;
  bit          m_wr;

  function automatic bit owner_req();
    if (m_own == 1) return abus.iREN;
    if (m_own == 2) return abus.dREN | abus.dWEN;
    return 1'b0;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_own <= 0; m_addr <= '0; m_data <= '0; m_wr <= 0; m_streak <= 0; m_wait <= 0;
    end else if (m_own == 0) begin
      if (!abus.iREN) m_streak <= 0;
      if ((abus.dREN || abus.dWEN) && (m_streak < MAXD || !abus.iREN)) begin
        m_own <= 2; m_addr <= abus.daddr; m_data <= abus.dstore; m_wr <= abus.dWEN; m_wait <= 0;
      end else if (abus.iREN) begin
        m_own <= 1; m_addr <= abus.iaddr; m_wait <= 0;
      end
    end else begin
      if (!owner_req()) m_own <= 0;
      else if (abus.ram_ready) begin
        m_own <= 0;
        if (m_own == 1) m_streak <= 0;
        else if (abus.iREN && m_streak < MAXD) m_streak <= m_streak + 1;
      end else if (m_wait == TO - 1) m_own <= 0;
      else m_wait <= m_wait + 1;
    end
  end

  bit last_ihit, last_dhit;

  always @(negedge CLK) begin
    bit e_ih, e_dh, e_err;
    e_ih  = (m_own == 1) && abus.iREN && abus.ram_ready;
    e_dh  = (m_own == 2) && (abus.dREN || abus.dWEN) && abus.ram_ready;
    e_err = (m_own != 0) && owner_req() && !abus.ram_ready && (m_wait == TO - 1);
    check("ramREN",   32'(abus.ramREN), 32'((m_own == 1) || (m_own == 2 && !m_wr)));
    check("ramWEN",   32'(abus.ramWEN), 32'(m_own == 2 && m_wr));
    check("ramaddr",  abus.ramaddr, m_addr);
    check("ramstore", abus.ramstore, m_data);
    check("ihit",     32'(abus.ihit), 32'(e_ih));
    check("dhit",     32'(abus.dhit), 32'(e_dh));
    check("iload",    abus.iload, e_ih ? abus.ramload : 32'h0);
    check("dload",    abus.dload, e_dh ? abus.ramload : 32'h0);
    check("err",      32'(abus.err), 32'(e_err));
    last_ihit = abus.ihit;
    last_dhit = abus.dhit;
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    string hits;
    int    mode;
    RST = 1;
    abus.iREN = 0; abus.iaddr = '0; abus.dREN = 0; abus.dWEN = 0;
    abus.daddr = '0; abus.dstore = '0; abus.ramload = '0; abus.ram_ready = 0;
    repeat (3) step();
    @(negedge CLK);
    check("rst_ramREN", 32'(abus.ramREN), 32'h0);
    check("rst_ramaddr", abus.ramaddr, 32'h0);
    step();
    RST = 0;
    step();

    // Instruction read, ready on the third access cycle.
    abus.iREN = 1; abus.iaddr = 32'h40;
    step();
    @(negedge CLK);
    check("i_ramREN", 32'(abus.ramREN), 32'h1);
    check("i_ramaddr", abus.ramaddr, 32'h40);
    check("i_early_hit", 32'(abus.ihit), 32'h0);
    step(); step();
    abus.ram_ready = 1; abus.ramload = 32'h8C010004;
    @(negedge CLK);
    check("i_hit", 32'(abus.ihit), 32'h1);
    check("i_iload", abus.iload, 32'h8C010004);
    step();
    abus.iREN = 0; abus.ram_ready = 0;
    @(negedge CLK);
    check("i_idle_ren", 32'(abus.ramREN), 32'h0);
    check("i_idle_hit", 32'(abus.ihit), 32'h0);
    step();

    // Simultaneous fetch and write: data first, a bubble, then fetch.
    abus.iREN = 1; abus.dWEN = 1; abus.daddr = 32'h100; abus.dstore = 32'hDEADBEEF;
    abus.ram_ready = 1;
    step();
    @(negedge CLK);
    check("s_ramWEN", 32'(abus.ramWEN), 32'h1);
    check("s_ramstore", abus.ramstore, 32'hDEADBEEF);
    check("s_ramaddr", abus.ramaddr, 32'h100);
    check("s_dhit", 32'(abus.dhit), 32'h1);
    step();
    abus.dWEN = 0;
    @(negedge CLK);
    check("s_bubble", 32'({abus.ramREN, abus.ramWEN, abus.ihit}), 32'h0);
    step();
    @(negedge CLK);
    check("s_iacc", 32'({abus.ramREN, abus.ramWEN, abus.ihit}), 32'b101);
    check("s_iaddr", abus.ramaddr, 32'h40);
    step();
    abus.iREN = 0; abus.ram_ready = 0;
    step(); step();

    // Starvation guard: with both requests held, four data grants per fetch.
    abus.iREN = 1; abus.dREN = 1; abus.ram_ready = 1;
    hits = "";
    for (int c = 0; c < 60 && hits.len() < 10; c++) begin
      @(negedge CLK);
      if (abus.dhit) hits = {hits, "D"};
      if (abus.ihit) hits = {hits, "I"};
      step();
    end
    n_checks++;
    if (hits != "DDDDIDDDDI") begin
      n_fail++;
      $display("FAIL streak_pattern: got %s expected DDDDIDDDDI", hits);
    end
    abus.iREN = 0; abus.dREN = 0; abus.ram_ready = 0;
    repeat (3) step();

    // Timeout: RAM never readies.
    abus.dREN = 1; abus.daddr = 32'h200;
    step();
    for (int c = 1; c <= TO; c++) begin
      @(negedge CLK);
      check($sformatf("t_err_c%0d", c), 32'(abus.err), 32'(c == TO));
      check($sformatf("t_dhit_c%0d", c), 32'(abus.dhit), 32'h0);
      if (c < TO) step();
    end
    step();
    @(negedge CLK);
    check("t_idle", 32'({abus.ramREN, abus.err}), 32'h0);
    step();
    @(negedge CLK);
    check("t_regrant", 32'(abus.ramREN), 32'h1);
    step();
    abus.dREN = 0;
    step(); step();

    // Withdrawn fetch, then reset in the middle of a data access.
    abus.iREN = 1; abus.iaddr = 32'h80;
    step();
    @(negedge CLK);
    check("w_ramREN", 32'(abus.ramREN), 32'h1);
    step();
    abus.iREN = 0;
    @(negedge CLK);
    check("w_nohit", 32'({abus.ihit, abus.err}), 32'h0);
    step();
    @(negedge CLK);
    check("w_idle", 32'({abus.ramREN, abus.err}), 32'h0);
    step();
    abus.dREN = 1;
    step();
    @(negedge CLK);
    check("r_dacc", 32'(abus.ramREN), 32'h1);
    #1 abus.ram_ready = 1;
    #1 RST = 1;
    #1;
    check("r_outs", 32'({abus.ramREN, abus.ramWEN, abus.dhit}), 32'h0);
    check("r_state", 32'(dut.state), 32'(IDLE));
    check("r_streak", 32'(dut.streak), 32'h0);
    abus.dREN = 0; abus.ram_ready = 0;
    step();
    RST = 0;
    step();

    // Randomized traffic; every cycle is checked against the model.
    mode = 0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (n % 200 == 0) mode = $urandom_range(0, 3);
      if (abus.iREN) begin
        if (last_ihit || $urandom_range(0, 63) == 0) abus.iREN = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        abus.iREN = 1; abus.iaddr = $urandom & 32'hFFFF_FFFC;
      end
      if (abus.dREN || abus.dWEN) begin
        if (last_dhit || $urandom_range(0, 63) == 0) begin
          abus.dREN = 0; abus.dWEN = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) abus.dWEN = 1;
        else abus.dREN = 1;
        abus.daddr = $urandom; abus.dstore = $urandom;
      end
      case (mode)
        0:       abus.ram_ready = 1;
        1:       abus.ram_ready = ($urandom_range(0, 1) == 1);
        2:       abus.ram_ready = ($urandom_range(0, 7) == 0);
        default: abus.ram_ready = 0;
      endcase
      abus.ramload = $urandom;
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
